pcileech_button_ctl: RTL and testbench

// Input-side counterpart to the board top's LED/status outputs: conditions one raw active-low

---
 rtl/pcileech_button_ctl.sv | 126 ++++++++++++
 tb/tb_pcileech_button_ctl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_button_ctl.sv
// pcileech_button_ctl: synchronises, debounces and classifies one active-low push-button
// into level and single-cycle event outputs (press/release/short/long).
`default_nettype none

module pcileech_button_ctl #(
  parameter int PARAM_DEBOUNCE_CYCLES  = 1000000,
  parameter int PARAM_LONGPRESS_CYCLES = 500000000,
  parameter int PARAM_CNT_WIDTH        = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sw_n,
  output logic                       btn_down,
  output logic                       btn_press,
  output logic                       btn_release,
  output logic                       btn_short,
  output logic                       btn_long,
  output logic                       btn_long_active,
  output logic [PARAM_CNT_WIDTH-1:0] hold_cnt
);

  localparam logic [PARAM_CNT_WIDTH-1:0] CNT_ONE   = PARAM_CNT_WIDTH'(1);
  localparam logic [PARAM_CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [PARAM_CNT_WIDTH-1:0] DEB_LAST  = PARAM_CNT_WIDTH'(PARAM_DEBOUNCE_CYCLES - 1);
  localparam logic [PARAM_CNT_WIDTH-1:0] LONG_LAST = PARAM_CNT_WIDTH'(PARAM_LONGPRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HELD = 2'd1,
    S_LONG = 2'd2
  } state_t;

  state_t state;

  // Synchroniser flops carry the raw pin, so a preset of 1 means "released".
  (* ASYNC_REG = "TRUE" *) logic sync1;
  (* ASYNC_REG = "TRUE" *) logic sync2;

  logic                       sync_pressed;
  logic                       deb_level;
  logic [PARAM_CNT_WIDTH-1:0] deb_cnt;
  logic [PARAM_CNT_WIDTH-1:0] hold_next;

  assign sync_pressed = ~sync2;
  assign hold_next    = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + CNT_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      deb_cnt   <= '0;
      deb_level <= 1'b0;
    end else begin
      sync1 <= sw_n;
      sync2 <= sync1;
      if (sync_pressed != deb_level) begin
        if (deb_cnt == DEB_LAST) begin
          deb_level <= sync_pressed;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + CNT_ONE;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // The FSM reacts to deb_level one edge later, so btn_down moves together with its pulses.
  // The threshold compare sees the pre-increment count, landing btn_long LONGPRESS cycles after press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      btn_down        <= 1'b0;
      btn_press       <= 1'b0;
      btn_release     <= 1'b0;
      btn_short       <= 1'b0;
      btn_long        <= 1'b0;
      btn_long_active <= 1'b0;
      hold_cnt        <= '0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_short   <= 1'b0;
      btn_long    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (deb_level) begin
            btn_down  <= 1'b1;
            btn_press <= 1'b1;
            hold_cnt  <= '0;
            state     <= S_HELD;
          end
        end
        S_HELD: begin
          hold_cnt <= hold_next;
          if (!deb_level) begin
            btn_down    <= 1'b0;
            btn_release <= 1'b1;
            btn_short   <= 1'b1;
            state       <= S_IDLE;
          end else if (hold_cnt == LONG_LAST) begin
            btn_long        <= 1'b1;
            btn_long_active <= 1'b1;
            state           <= S_LONG;
          end
        end
        S_LONG: begin
          hold_cnt <= hold_next;
          if (!deb_level) begin
            btn_down        <= 1'b0;
            btn_release     <= 1'b1;
            btn_long_active <= 1'b0;
            state           <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pcileech_button_ctl.sv
// Bench for pcileech_button_ctl: directed and random pin waveforms, event-level reference model,
// scoreboard queue drained by a negedge monitor.
`default_nettype none

module tb_pcileech_button_ctl;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int W    = 5;
  localparam int HMAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sw_n = 1'b1;
  logic         btn_down, btn_press, btn_release, btn_short, btn_long, btn_long_active;
  logic [W-1:0] hold_cnt;

  pcileech_button_ctl #(
    .PARAM_DEBOUNCE_CYCLES (DEB),
    .PARAM_LONGPRESS_CYCLES(LONG),
    .PARAM_CNT_WIDTH       (W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sw_n           (sw_n),
    .btn_down       (btn_down),
    .btn_press      (btn_press),
    .btn_release    (btn_release),
    .btn_short      (btn_short),
    .btn_long       (btn_long),
    .btn_long_active(btn_long_active),
    .hold_cnt       (hold_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         down;
    logic         press;
    logic         rel;
    logic         shrt;
    logic         lng;
    logic         la;
    logic [W-1:0] hold;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the pin is seen two edges late; the debounced level flips once the seen
  // level has disagreed for DEB consecutive edges; press/release are reported one edge later.
  bit hist[$] = '{1'b0, 1'b0};
  int run = 0;
  bit deb = 1'b0;
  bit down = 1'b0;
  bit long_r = 1'b0;
  int p_time = 0;
  int hold = 0;
  int edge_no = 0;

  always @(posedge clk) begin
    out_t e;
    bit   seen;
    bit   deb_prev;
    e = '0;
    edge_no++;
    if (rst) begin
      hist   = '{1'b0, 1'b0};
      run    = 0;
      deb    = 1'b0;
      down   = 1'b0;
      long_r = 1'b0;
      hold   = 0;
    end else begin
      deb_prev = deb;
      seen = hist.pop_front();
      hist.push_back(~sw_n);
      if (seen != deb) begin
        run++;
        if (run == DEB) begin
          deb = seen;
          run = 0;
        end
      end else begin
        run = 0;
      end
      if (!down) begin
        if (deb_prev) begin
          down    = 1'b1;
          e.press = 1'b1;
          p_time  = edge_no;
          long_r  = 1'b0;
          hold    = 0;
        end
      end else begin
        hold = (edge_no - p_time > HMAX) ? HMAX : edge_no - p_time;
        if (!deb_prev) begin
          down   = 1'b0;
          e.rel  = 1'b1;
          e.shrt = !long_r;
          long_r = 1'b0;
        end else if (!long_r && (edge_no - p_time == LONG)) begin
          e.lng  = 1'b1;
          long_r = 1'b1;
        end
      end
      e.down = down;
      e.la   = down && long_r;
      e.hold = hold[W-1:0];
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    out_t e;
    out_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {btn_down, btn_press, btn_release, btn_short, btn_long, btn_long_active, hold_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got down/press/rel/short/long/la=%b%b%b%b%b%b hold=%0d, expected %b%b%b%b%b%b hold=%0d",
                 $time, a.down, a.press, a.rel, a.shrt, a.lng, a.la, a.hold,
                 e.down, e.press, e.rel, e.shrt, e.lng, e.la, e.hold);
      end
    end
  end

  task automatic drive(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      sw_n = lvl;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic lvl;
    int   n;
    bit   seen_press;
    rst  = 1'b1;
    sw_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({btn_down, btn_press, btn_release, btn_short, btn_long, btn_long_active, hold_cnt} !== '0) begin
      errors++;
      $display("FAIL reset state t=%0t: outputs not all zero during reset", $time);
    end
    rst = 1'b0;
    drive(1'b1, 5);
    // short press, then a long hold
    sw_n       = 1'b0;
    seen_press = 1'b0;
    for (int i = 0; i < DEB + 6; i++) begin
      @(posedge clk);
      #2;
      if (btn_press === 1'b1) begin
        seen_press = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen_press) begin
      errors++;
      $display("FAIL timeout t=%0t: btn_press not seen within %0d cycles of press", $time, DEB + 6);
    end
    drive(1'b0, 8); drive(1'b1, 12);
    drive(1'b0, 36); drive(1'b1, 12);
    // bounce that never settles
    drive(1'b0, 3); drive(1'b1, 1); drive(1'b0, 3); drive(1'b1, 10);
    // reset while long-held, button kept down
    drive(1'b0, 30); pulse_rst(); drive(1'b0, 12); drive(1'b1, 12);
    // saturation of the narrow hold counter
    drive(1'b0, 50); drive(1'b1, 12);
    // release one before, on, and one after the long threshold
    drive(1'b0, 19); drive(1'b1, 12);
    drive(1'b0, 20); drive(1'b1, 12);
    drive(1'b0, 21); drive(1'b1, 12);
    // randomized segments
    lvl = 1'b0;
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 11) == 0) pulse_rst();
      case ($urandom_range(0, 2))
        0: n = $urandom_range(1, 5);
        1: n = $urandom_range(6, 18);
        default: n = $urandom_range(19, 45);
      endcase
      drive(lvl, n);
      lvl = ~lvl;
    end
    drive(1'b1, 15);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
